// File: rtl/rtl_kernel_ctrl_pkg.sv
// Shared types and helpers for the RTL kernel control sequencer and sibling kernel tops.
package rtl_kernel_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE,
        LAUNCH,
        RUN,
        DONE
    } state_t;

    localparam int unsigned LP_ALIGN_BYTES = 64;
    localparam logic [31:0] LP_ALIGN_MASK  = ~(32'(LP_ALIGN_BYTES) - 32'd1);

    // Zero selects the default length; otherwise round up to the alignment,
    // saturating at the largest aligned value that fits in xfer_w bits.
    function automatic logic [63:0] align_len(
        input logic [63:0] len,
        input int unsigned xfer_w,
        input int unsigned align_bytes,
        input logic [63:0] default_len
    );
        logic [63:0] mask;
        logic [63:0] max_len;
        mask    = ~(64'(align_bytes) - 64'd1);
        max_len = ((64'd1 << xfer_w) - 64'd1) & mask;
        if (len == '0) begin
            return default_len;
        end
        if (len > max_len) begin
            return max_len;
        end
        return (len + 64'(align_bytes) - 64'd1) & mask;
    endfunction

endpackage

// File: rtl/rtl_kernel_ctrl_done_tracker.sv
// Sticky per-channel done bits; all_done sees the current cycle's pulses as well as the latch.
module rtl_kernel_ctrl_done_tracker
    import rtl_kernel_ctrl_pkg::*;
#(
    parameter int unsigned C_NUM_CHANNELS = 4
) (
    input  logic                      ap_clk,
    input  logic                      areset,
    input  logic                      clear,
    input  logic                      track_en,
    input  logic [C_NUM_CHANNELS-1:0] mask,
    input  logic [C_NUM_CHANNELS-1:0] ch_done,
    output logic                      all_done
);

    logic [C_NUM_CHANNELS-1:0] done_latch;

    always_ff @(posedge ap_clk or posedge areset) begin
        if (areset) begin
            done_latch <= '0;
        end else if (clear) begin
            done_latch <= '0;
        end else if (track_en) begin
            done_latch <= done_latch | (ch_done & mask);
        end
    end

    assign all_done = ((done_latch | ch_done) & mask) == mask;

endmodule

// File: rtl/rtl_kernel_ctrl_sequencer.sv
// ap_ctrl_chain sequencer: latches args, launches enabled channels, aggregates dones.
// Optional busy-cycle counter enabled by defining RTL_KERNEL_CTRL_PERF_CNT_EN.
module rtl_kernel_ctrl_sequencer
    import rtl_kernel_ctrl_pkg::*;
#(
    parameter int unsigned C_NUM_CHANNELS      = 4,
    parameter int unsigned C_XFER_SIZE_WIDTH   = 32,
    parameter int unsigned C_DEFAULT_LEN_BYTES = 16384,
    parameter int unsigned C_ALIGN_BYTES       = LP_ALIGN_BYTES,
    parameter int unsigned C_PERF_CNT_WIDTH    = 32
) (
    input  logic                         ap_clk,
    input  logic                         areset,
    input  logic                         ap_start,
    input  logic                         ap_continue,
    output logic                         ap_ready,
    output logic                         ap_done,
    output logic                         ap_idle,
    input  logic [C_XFER_SIZE_WIDTH-1:0] scalar00,
    input  logic [C_NUM_CHANNELS-1:0]    scalar01,
    output logic [C_XFER_SIZE_WIDTH-1:0] ctrl_xfer_size_in_bytes,
    output logic [C_NUM_CHANNELS-1:0]    ch_start,
    input  logic [C_NUM_CHANNELS-1:0]    ch_done,
    output logic [C_PERF_CNT_WIDTH-1:0]  busy_cycles
);

    state_t                         state;
    logic [C_NUM_CHANNELS-1:0]      mask;
    logic                           launch_req;
    logic                           track_en;
    logic                           all_done;
    logic [C_XFER_SIZE_WIDTH-1:0]   size_aligned;

    assign launch_req   = (state == IDLE) && ap_start;
    assign track_en     = (state == RUN);
    assign size_aligned = C_XFER_SIZE_WIDTH'(align_len(64'(scalar00), C_XFER_SIZE_WIDTH,
                                                       C_ALIGN_BYTES, 64'(C_DEFAULT_LEN_BYTES)));

    rtl_kernel_ctrl_done_tracker #(
        .C_NUM_CHANNELS (C_NUM_CHANNELS)
    ) u_done_tracker (
        .ap_clk   (ap_clk),
        .areset   (areset),
        .clear    (launch_req),
        .track_en (track_en),
        .mask     (mask),
        .ch_done  (ch_done),
        .all_done (all_done)
    );

    always_ff @(posedge ap_clk or posedge areset) begin
        if (areset) begin
            state                   <= IDLE;
            ap_idle                 <= 1'b1;
            ap_ready                <= 1'b0;
            ap_done                 <= 1'b0;
            ch_start                <= '0;
            mask                    <= '0;
            ctrl_xfer_size_in_bytes <= C_XFER_SIZE_WIDTH'(C_DEFAULT_LEN_BYTES);
        end else begin
            ap_ready <= 1'b0;
            ch_start <= '0;
            case (state)
                IDLE: begin
                    if (ap_start) begin
                        state                   <= LAUNCH;
                        ap_idle                 <= 1'b0;
                        ap_ready                <= 1'b1;
                        mask                    <= scalar01;
                        ch_start                <= scalar01;
                        ctrl_xfer_size_in_bytes <= size_aligned;
                    end
                end
                LAUNCH: begin
                    if (mask == '0) begin
                        state   <= DONE;
                        ap_done <= 1'b1;
                    end else begin
                        state <= RUN;
                    end
                end
                RUN: begin
                    if (all_done) begin
                        state   <= DONE;
                        ap_done <= 1'b1;
                    end
                end
                DONE: begin
                    if (ap_continue) begin
                        state   <= IDLE;
                        ap_done <= 1'b0;
                        ap_idle <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef RTL_KERNEL_CTRL_PERF_CNT_EN
    logic [C_PERF_CNT_WIDTH-1:0] perf_cnt;

    always_ff @(posedge ap_clk or posedge areset) begin
        if (areset) begin
            perf_cnt <= '0;
        end else if (launch_req) begin
            perf_cnt <= '0;
        end else if (track_en && (perf_cnt != '1)) begin
            perf_cnt <= perf_cnt + C_PERF_CNT_WIDTH'(1);
        end
    end

    assign busy_cycles = perf_cnt;
`else
    assign busy_cycles = '0;
`endif

endmodule
